// File: rtl/rhd_pkg.sv
// Shared constants, FSM state type and CONVERT command encoding for the
// Intan RHD SPI master.
package rhd_pkg;

  localparam int unsigned CMD_W              = 16;
  localparam logic [1:0]  OP_CONVERT         = 2'b00;
  localparam int unsigned DEF_HALF_SCLK      = 4;
  localparam int unsigned DEF_CS_HIGH_CYCLES = 16;
  localparam int unsigned DEF_SAMPLE_DELAY   = 2;
  localparam int unsigned DEF_NUM_CH         = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_LEAD  = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_TRAIL = 3'd3,
    ST_CS_HIGH  = 3'd4
  } rhd_state_e;

  function automatic logic [CMD_W-1:0] convert_cmd(input logic [4:0] ch);
    return {OP_CONVERT, 1'b0, ch, 8'h00};
  endfunction

endpackage

// File: rtl/rhd_spi_master_if.sv
// SPI pins to the RHD device plus the decoded sample stream leaving the master.
interface rhd_spi_master_if;

  logic        cs;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic [4:0]  data_ch;
  logic        data_valid;

  modport master (
    output cs, sclk, mosi, data_a, data_b, data_ch, data_valid,
    input  miso
  );

  modport slave (
    input  cs, sclk, mosi,
    output miso
  );

endinterface

// File: rtl/rhd_sclk_gen.sv
// SCLK generator: 16 periods (32 halves, high half first) after a start pulse,
// with strokes marking the falling edge, both MISO sample points and the end.
module rhd_sclk_gen
  import rhd_pkg::*;
#(
  parameter int unsigned HALF_SCLK    = DEF_HALF_SCLK,
  parameter int unsigned SAMPLE_DELAY = DEF_SAMPLE_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic sclk,
  output logic fall,
  output logic sample_a,
  output logic sample_b,
  output logic last_half,
  output logic done
);

  localparam logic [3:0] HC_END    = 4'(HALF_SCLK - 1);
  localparam logic [3:0] HC_SAMPLE = 4'(SAMPLE_DELAY);
  localparam logic [4:0] HALF_LAST = 5'(2 * CMD_W - 1);

  logic       active_r;
  logic       sclk_r;
  logic [3:0] hcnt_r;
  logic [4:0] half_r;
  logic       hc_end_s;

  // Stroke decode; an even half index is the high half of a period
  always_comb begin
    hc_end_s  = (hcnt_r == HC_END);
    fall      = active_r && !half_r[0] && hc_end_s;
    sample_a  = active_r && !half_r[0] && (hcnt_r == HC_SAMPLE);
    sample_b  = active_r &&  half_r[0] && (hcnt_r == HC_SAMPLE);
    last_half = (half_r == HALF_LAST);
    done      = active_r && last_half && hc_end_s;
  end

  // Half-period counter and registered SCLK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= 1'b0;
      sclk_r   <= 1'b0;
      hcnt_r   <= 4'd0;
      half_r   <= 5'd0;
    end else if (start) begin
      active_r <= 1'b1;
      sclk_r   <= 1'b1;
      hcnt_r   <= 4'd0;
      half_r   <= 5'd0;
    end else if (active_r) begin
      if (hc_end_s) begin
        hcnt_r <= 4'd0;
        if (last_half) begin
          active_r <= 1'b0;
          sclk_r   <= 1'b0;
        end else begin
          half_r <= half_r + 5'd1;
          sclk_r <= half_r[0];
        end
      end else begin
        hcnt_r <= hcnt_r + 4'd1;
      end
    end
  end

  assign sclk = sclk_r;

endmodule

// File: rtl/rhd_spi_master.sv
// RHD2000 SPI master: sweeps CONVERT(ch) over NUM_CH channels and returns the
// DDR result words, re-tagged for the device's two-frame pipeline.
module rhd_spi_master
  import rhd_pkg::*;
#(
  parameter int unsigned HALF_SCLK      = DEF_HALF_SCLK,
  parameter int unsigned CS_HIGH_CYCLES = DEF_CS_HIGH_CYCLES,
  parameter int unsigned SAMPLE_DELAY   = DEF_SAMPLE_DELAY,
  parameter int unsigned NUM_CH         = DEF_NUM_CH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             busy,
  rhd_spi_master_if.master spi
);

  localparam logic [7:0] HALF_END = 8'(HALF_SCLK - 1);
  localparam logic [7:0] CSH_END  = 8'(CS_HIGH_CYCLES - 1);
  localparam logic [4:0] CH_MASK  = 5'(NUM_CH - 1);

  rhd_state_e       state_r, state_s;
  logic [7:0]       cnt_r;
  logic [4:0]       ch_r, ch_next_s;
  logic [CMD_W-1:0] cmd_sr_r, cmd_next_s;
  logic [1:0]       frames_r;
  logic             cs_r, busy_r, data_valid_r;
  logic [15:0]      sh_a_r, sh_b_r, data_a_r, data_b_r;
  logic [4:0]       data_ch_r;
  logic             frame_start_s, gen_start_s, cs_low_s, publish_s;
  logic             sclk_s, fall_s, sample_a_s, sample_b_s, last_half_s, done_s;

  rhd_sclk_gen #(
    .HALF_SCLK    (HALF_SCLK),
    .SAMPLE_DELAY (SAMPLE_DELAY)
  ) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (gen_start_s),
    .sclk      (sclk_s),
    .fall      (fall_s),
    .sample_a  (sample_a_s),
    .sample_b  (sample_b_s),
    .last_half (last_half_s),
    .done      (done_s)
  );

  // Frame sequencing next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:     if (enable) state_s = ST_CS_LEAD; else state_s = ST_IDLE;
      ST_CS_LEAD:  if (cnt_r == HALF_END) state_s = ST_SHIFT; else state_s = ST_CS_LEAD;
      ST_SHIFT:    if (done_s) state_s = ST_CS_TRAIL; else state_s = ST_SHIFT;
      ST_CS_TRAIL: if (cnt_r == HALF_END) state_s = ST_CS_HIGH; else state_s = ST_CS_TRAIL;
      ST_CS_HIGH: begin
        if (cnt_r == CSH_END) begin
          if (enable) state_s = ST_CS_LEAD; else state_s = ST_IDLE;
        end else begin
          state_s = ST_CS_HIGH;
        end
      end
      default:     state_s = ST_IDLE;
    endcase
  end

  // Per-frame strobes; the channel sweep restarts at 0 when leaving IDLE
  always_comb begin
    frame_start_s = (state_s == ST_CS_LEAD) && (state_r != ST_CS_LEAD);
    gen_start_s   = (state_r == ST_CS_LEAD) && (state_s == ST_SHIFT);
    cs_low_s      = (state_s == ST_CS_LEAD) || (state_s == ST_SHIFT) ||
                    (state_s == ST_CS_TRAIL);
    if (state_r == ST_IDLE) ch_next_s = 5'd0;
    else                    ch_next_s = (ch_r + 5'd1) & CH_MASK;
    cmd_next_s = convert_cmd(ch_next_s);
    publish_s  = sample_b_s && last_half_s && (frames_r == 2'd2);
  end

  // State, command shifter, MISO capture and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 8'd0;
      ch_r         <= 5'd0;
      frames_r     <= 2'd0;
      cmd_sr_r     <= '0;
      cs_r         <= 1'b1;
      busy_r       <= 1'b0;
      sh_a_r       <= 16'd0;
      sh_b_r       <= 16'd0;
      data_a_r     <= 16'd0;
      data_b_r     <= 16'd0;
      data_ch_r    <= 5'd0;
      data_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cs_r         <= !cs_low_s;
      busy_r       <= (state_s != ST_IDLE);
      data_valid_r <= publish_s;
      if ((state_s != state_r) || (state_s == ST_IDLE)) cnt_r <= 8'd0;
      else                                              cnt_r <= cnt_r + 8'd1;
      if (frame_start_s) begin
        ch_r     <= ch_next_s;
        cmd_sr_r <= cmd_next_s;
      end else if (fall_s) begin
        cmd_sr_r <= {cmd_sr_r[CMD_W-2:0], 1'b0};
      end
      // Results lag the issued channel by two frames inside the device
      if (frame_start_s && (state_r == ST_IDLE)) frames_r <= 2'd0;
      else if (done_s && (frames_r != 2'd2))     frames_r <= frames_r + 2'd1;
      if (sample_a_s) sh_a_r <= {sh_a_r[14:0], spi.miso};
      if (sample_b_s) sh_b_r <= {sh_b_r[14:0], spi.miso};
      if (publish_s) begin
        data_a_r  <= sh_a_r;
        data_b_r  <= {sh_b_r[14:0], spi.miso};
        data_ch_r <= (ch_r - 5'd2) & CH_MASK;
      end
    end
  end

  assign spi.cs         = cs_r;
  assign spi.sclk       = sclk_s;
  assign spi.mosi       = cmd_sr_r[CMD_W-1];
  assign spi.data_a     = data_a_r;
  assign spi.data_b     = data_b_r;
  assign spi.data_ch    = data_ch_r;
  assign spi.data_valid = data_valid_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_rhd_spi_master.sv
// Directed bench for rhd_spi_master with a behavioural RHD device that decodes
// MOSI and answers with DDR words (tag, tag+32) two frames later.
module tb_rhd_spi_master;
  import rhd_pkg::*;

  localparam int HALF   = 4;
  localparam int CSH    = 16;
  localparam int SD     = 2;
  localparam int NCH    = 32;
  localparam int CS_LOW = HALF + 2 * CMD_W * HALF + HALF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic busy;
  bit   pat_mode = 1'b0;

  rhd_spi_master_if spi ();

  rhd_spi_master #(
    .HALF_SCLK(HALF), .CS_HIGH_CYCLES(CSH), .SAMPLE_DELAY(SD), .NUM_CH(NCH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .busy(busy), .spi(spi)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] cmd_q[$];
  logic [15:0] va_q[$];
  logic [15:0] vb_q[$];
  logic [4:0]  vch_q[$];
  int valid_cnt = 0, cs_fall_cnt = 0, hold_viol = 0;
  int cs_low_len = 0, cs_high_len = 0, sclk_period = 0, rises = 0, rises_last = 0;
  int cs_cnt = 0, sclk_cnt = 0, k = 0;
  logic [15:0] rx = 16'd0, tx_a = 16'd0, tx_b = 16'd0, prev_a = 16'd0, prev_b = 16'd0;
  logic [4:0]  p1 = 5'd0, p2 = 5'd0, prev_ch = 5'd0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  // RHD device model and bus monitor, evaluated on the inactive clock edge
  always @(negedge clk) begin
    if (rst) begin
      k = 0; rx = 16'd0; p1 = 5'd0; p2 = 5'd0; spi.miso = 1'b0;
      prev_cs = 1'b1; prev_sclk = 1'b0; cs_cnt = 0; sclk_cnt = 0; rises = 0;
    end else begin
      cs_cnt++;
      sclk_cnt++;
      if (!spi.cs && prev_cs) begin
        cs_fall_cnt++; cs_high_len = cs_cnt; cs_cnt = 0; k = 0; rises = 0; rx = 16'd0;
        tx_a = pat_mode ? 16'hA5A5 : {11'd0, p2};
        tx_b = pat_mode ? 16'h5A5A : tx_a + 16'd32;
      end
      if (spi.cs && !prev_cs) begin
        cs_low_len = cs_cnt; cs_cnt = 0; rises_last = rises;
        cmd_q.push_back(rx);
        p2 = p1; p1 = rx[12:8];
      end
      if (spi.sclk && !prev_sclk) begin
        sclk_period = sclk_cnt; sclk_cnt = 0; rises++;
        rx = {rx[14:0], spi.mosi};
        if (k < 16) spi.miso = tx_a[15-k];
      end
      if (!spi.sclk && prev_sclk) begin
        if (k < 16) spi.miso = tx_b[15-k];
        k++;
      end
    end
    if (spi.data_valid) begin
      valid_cnt++;
      va_q.push_back(spi.data_a); vb_q.push_back(spi.data_b); vch_q.push_back(spi.data_ch);
    end else if (!rst && (spi.data_a !== prev_a || spi.data_b !== prev_b || spi.data_ch !== prev_ch)) begin
      hold_viol++;
    end
    prev_a = spi.data_a; prev_b = spi.data_b; prev_ch = spi.data_ch;
    prev_cs = spi.cs; prev_sclk = spi.sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int base, v0, f0;

  initial begin
    // Reset values
    step(3);
    check("rst_cs", 32'(spi.cs), 32'd1);
    check("rst_sclk", 32'(spi.sclk), 32'd0);
    check("rst_mosi", 32'(spi.mosi), 32'd0);
    check("rst_data_a", 32'(spi.data_a), 32'd0);
    check("rst_data_b", 32'(spi.data_b), 32'd0);
    check("rst_data_ch", 32'(spi.data_ch), 32'd0);
    check("rst_valid", 32'(spi.data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dut.state_r), 32'(ST_IDLE));

    // Continuous sweep: 36 frames give exactly 34 published results
    rst = 1'b0;
    enable = 1'b1;
    step(1);
    check("cs_first_clk", 32'(spi.cs), 32'd0);
    step(5499);
    check("busy_run", 32'(busy), 32'd1);
    check("n_cmds", 32'(cmd_q.size()), 32'd36);
    check("n_valid", 32'(valid_cnt), 32'd34);
    check("cmd0", 32'(cmd_q[0]), 32'h0000);
    check("cmd1", 32'(cmd_q[1]), 32'h0100);
    check("cmd2", 32'(cmd_q[2]), 32'h0200);
    check("cmd31", 32'(cmd_q[31]), 32'h1F00);
    check("cmd32_wrap", 32'(cmd_q[32]), 32'h0000);
    check("cs_low_len", 32'(cs_low_len), 32'(CS_LOW));
    check("cs_high_len", 32'(cs_high_len), 32'(CSH));
    check("sclk_period", 32'(sclk_period), 32'(2 * HALF));
    check("sclk_rises", 32'(rises_last), 32'd16);
    check("first_a", 32'(va_q[0]), 32'h0000);
    check("first_b", 32'(vb_q[0]), 32'h0020);
    for (int i = 0; i < 34; i++) begin
      check("seq_ch", 32'(vch_q[i]), 32'(i % NCH));
      check("seq_a", 32'(va_q[i]), 32'(i % NCH));
      check("seq_b", 32'(vb_q[i]), 32'(va_q[i] + 16'd32));
    end

    // Drop enable after the 5th SCLK rise of frame 37 (ch 4, tag 2)
    for (int i = 0; i < 400 && !(spi.cs == 1'b0 && rises == 5); i++) step(1);
    check("edge5_reached", 32'(rises), 32'd5);
    enable = 1'b0;
    v0 = valid_cnt;
    f0 = cs_fall_cnt;
    step(300);
    check("drop_valid", 32'(valid_cnt), 32'(v0 + 1));
    check("drop_tag", 32'(vch_q[vch_q.size()-1]), 32'd2);
    check("drop_no_frame", 32'(cs_fall_cnt), 32'(f0));
    check("drop_cs", 32'(spi.cs), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_state", 32'(dut.state_r), 32'(ST_IDLE));

    // Fixed DDR pattern; restart from IDLE so first result is on frame 3
    pat_mode = 1'b1;
    base = cmd_q.size();
    v0 = valid_cnt;
    f0 = cs_fall_cnt;
    enable = 1'b1;
    for (int i = 0; i < 800 && valid_cnt == v0; i++) step(1);
    check("pat_valid", 32'(valid_cnt), 32'(v0 + 1));
    check("pat_frame3", 32'(cs_fall_cnt - f0), 32'd3);
    check("pat_restart_cmd", 32'(cmd_q[base]), 32'h0000);
    check("pat_a", 32'(spi.data_a), 32'hA5A5);
    check("pat_b", 32'(spi.data_b), 32'h5A5A);
    check("pat_ch", 32'(spi.data_ch), 32'd0);

    // Reset in the middle of an eligible frame
    for (int i = 0; i < 400 && !(spi.cs == 1'b0 && rises == 9); i++) step(1);
    check("edge9_reached", 32'(rises), 32'd9);
    v0 = valid_cnt;
    rst = 1'b1;
    #1;
    check("abort_cs", 32'(spi.cs), 32'd1);
    check("abort_sclk", 32'(spi.sclk), 32'd0);
    step(3);
    check("abort_valid", 32'(valid_cnt), 32'(v0));
    check("abort_state", 32'(dut.state_r), 32'(ST_IDLE));
    check("abort_data_a", 32'(spi.data_a), 32'd0);
    base = cmd_q.size();
    rst = 1'b0;
    for (int i = 0; i < 400 && cmd_q.size() == base; i++) step(1);
    check("restart_cmd", 32'(cmd_q[base]), 32'h0000);
    step(250);
    check("restart_no_valid", 32'(valid_cnt), 32'(v0));
    for (int i = 0; i < 400 && valid_cnt == v0; i++) step(1);
    check("restart_valid", 32'(valid_cnt), 32'(v0 + 1));
    check("restart_ch", 32'(spi.data_ch), 32'd0);
    check("restart_a", 32'(spi.data_a), 32'hA5A5);
    check("hold", 32'(hold_viol), 32'd0);
    enable = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
